// File: rtl/mem_port_arbiter_if.sv
// External memory port bundle shared by the IF/ME arbiter and the memory.
//   master : arbiter side  (drives address, write data and strobes)
//   slave  : memory side   (drives ext_Ack and ext_RdData)
// Signals:
//   ext_Addr    ADDR_W  external address
//   ext_WrData  DATA_W  external write data
//   ext_RdEn    1       read strobe, held until ack
//   ext_WrEn    1       write strobe, held until ack
//   ext_Ack     1       completion; read data valid in the same cycle
//   ext_RdData  DATA_W  read data
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] ext_Addr;
    logic [DATA_W-1:0] ext_WrData;
    logic              ext_RdEn;
    logic              ext_WrEn;
    logic              ext_Ack;
    logic [DATA_W-1:0] ext_RdData;

    modport master (
        output ext_Addr, ext_WrData, ext_RdEn, ext_WrEn,
        input  ext_Ack, ext_RdData
    );

    modport slave (
        input  ext_Addr, ext_WrData, ext_RdEn, ext_WrEn,
        output ext_Ack, ext_RdData
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one external memory port between instruction fetch (IF)
// and the memory stage (ME). ME has priority; a one-shot "owed" flag lets a
// passed-over fetch win the next contended grant. A watchdog aborts accesses
// that are never acknowledged and raises a sticky bus_err.
// Ports:
//   clock, reset            clock and synchronous active-high reset
//   if_ReqEn/if_Addr        fetch read request (held until if_Done)
//   if_RdData/if_Done       fetched word and one-cycle completion pulse
//   me_RdEn/me_WrEn         ME load / store request (held until me_Done)
//   me_Addr/me_WrData       ME address and store data
//   me_RdData/me_Done       load data and one-cycle completion pulse
//   stall                   pipeline freeze (combinational)
//   bus_err                 sticky timeout flag
//   ext                     external memory bus (master side)
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_ReqEn,
    input  logic [ADDR_W-1:0] if_Addr,
    output logic [DATA_W-1:0] if_RdData,
    output logic              if_Done,
    input  logic              me_RdEn,
    input  logic              me_WrEn,
    input  logic [ADDR_W-1:0] me_Addr,
    input  logic [DATA_W-1:0] me_WrData,
    output logic [DATA_W-1:0] me_RdData,
    output logic              me_Done,
    output logic              stall,
    output logic              bus_err,
    mem_port_arbiter_if.master ext
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        INST = 2'd2
    } arbState_e;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    arbState_e         state;
    arbState_e         nextState;
    logic              ifOwed;
    logic              nextOwed;
    logic [7:0]        timeoutCnt;
    logic [7:0]        cntInc;
    logic              grantMe;
    logic              grantIf;
    logic              ackSeen;
    logic              abort;
    logic              meReq;
    logic [ADDR_W-1:0] addrReg;
    logic [DATA_W-1:0] wrDataReg;
    logic              rdStrobeReg;
    logic              wrStrobeReg;

    assign meReq = me_RdEn | me_WrEn;

    // Next-state, grant and completion decode.
    always_comb begin
        nextState = state;
        nextOwed  = ifOwed;
        grantMe   = 1'b0;
        grantIf   = 1'b0;
        ackSeen   = 1'b0;
        abort     = 1'b0;
        cntInc    = timeoutCnt + 8'd1;
        case (state)
            IDLE: begin
                if (meReq) begin
                    if (ifOwed && if_ReqEn) begin
                        nextState = INST;
                        nextOwed  = 1'b0;
                        grantIf   = 1'b1;
                    end else begin
                        // Fetch was passed over: it wins the next contention.
                        nextState = DATA;
                        nextOwed  = if_ReqEn;
                        grantMe   = 1'b1;
                    end
                end else if (if_ReqEn) begin
                    nextState = INST;
                    nextOwed  = 1'b0;
                    grantIf   = 1'b1;
                end else begin
                    nextState = IDLE;
                end
            end
            DATA, INST: begin
                // An ack in the final watchdog cycle still completes normally.
                if (ext.ext_Ack) begin
                    ackSeen   = 1'b1;
                    nextState = IDLE;
                end else if (cntInc == TIMEOUT_CNT) begin
                    abort     = 1'b1;
                    nextState = IDLE;
                end else begin
                    nextState = state;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // FSM state, fairness flag and watchdog counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            ifOwed     <= 1'b0;
            timeoutCnt <= 8'd0;
        end else begin
            state  <= nextState;
            ifOwed <= nextOwed;
            if (grantMe || grantIf) begin
                timeoutCnt <= 8'd0;
            end else if (state != IDLE) begin
                timeoutCnt <= cntInc;
            end else begin
                timeoutCnt <= timeoutCnt;
            end
        end
    end

    // Grant latching: the winner's request drives the external bus.
    always_ff @(posedge clock) begin
        if (reset) begin
            addrReg     <= '0;
            wrDataReg   <= '0;
            rdStrobeReg <= 1'b0;
            wrStrobeReg <= 1'b0;
        end else if (grantMe) begin
            addrReg     <= me_Addr;
            wrDataReg   <= me_WrData;
            // A simultaneous read and write becomes a write only.
            rdStrobeReg <= ~me_WrEn;
            wrStrobeReg <= me_WrEn;
        end else if (grantIf) begin
            addrReg     <= if_Addr;
            wrDataReg   <= '0;
            rdStrobeReg <= 1'b1;
            wrStrobeReg <= 1'b0;
        end else if (ackSeen || abort) begin
            rdStrobeReg <= 1'b0;
            wrStrobeReg <= 1'b0;
        end else begin
            rdStrobeReg <= rdStrobeReg;
            wrStrobeReg <= wrStrobeReg;
        end
    end

    // Completion pulses, returned read data and sticky error flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            if_Done   <= 1'b0;
            me_Done   <= 1'b0;
            if_RdData <= '0;
            me_RdData <= '0;
            bus_err   <= 1'b0;
        end else begin
            if_Done <= (ackSeen || abort) && (state == INST);
            me_Done <= (ackSeen || abort) && (state == DATA);
            if (state == INST && ackSeen) begin
                if_RdData <= ext.ext_RdData;
            end else if (state == INST && abort) begin
                if_RdData <= '0;
            end else begin
                if_RdData <= if_RdData;
            end
            if (state == DATA && ackSeen && rdStrobeReg) begin
                me_RdData <= ext.ext_RdData;
            end else if (state == DATA && abort) begin
                me_RdData <= '0;
            end else begin
                me_RdData <= me_RdData;
            end
            if (abort) begin
                bus_err <= 1'b1;
            end else begin
                bus_err <= bus_err;
            end
        end
    end

    assign ext.ext_Addr   = addrReg;
    assign ext.ext_WrData = wrDataReg;
    assign ext.ext_RdEn   = rdStrobeReg;
    assign ext.ext_WrEn   = wrStrobeReg;

    assign stall = (meReq & ~me_Done) | (if_ReqEn & ~if_Done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter. Directed stimulus pushes the
// expected completion (owner and read data) into a queue; a monitor pops
// and compares whenever a Done pulse appears. A small memory responder
// acknowledges accesses after a programmable delay.
module tb_mem_port_arbiter;

    typedef struct {
        bit          isMe;
        logic [31:0] data;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_ReqEn;
    logic [31:0] if_Addr;
    logic [31:0] if_RdData;
    logic        if_Done;
    logic        me_RdEn;
    logic        me_WrEn;
    logic [31:0] me_Addr;
    logic [31:0] me_WrData;
    logic [31:0] me_RdData;
    logic        me_Done;
    logic        stall;
    logic        bus_err;

    int   compared   = 0;
    int   mismatched = 0;
    exp_t expQ[$];

    bit   memOn    = 1'b1;
    int   ackDelay = 0;
    int   busyCnt  = 0;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) extBus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .if_ReqEn (if_ReqEn),
        .if_Addr  (if_Addr),
        .if_RdData(if_RdData),
        .if_Done  (if_Done),
        .me_RdEn  (me_RdEn),
        .me_WrEn  (me_WrEn),
        .me_Addr  (me_Addr),
        .me_WrData(me_WrData),
        .me_RdData(me_RdData),
        .me_Done  (me_Done),
        .stall    (stall),
        .bus_err  (bus_err),
        .ext      (extBus.master)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        if (addr == 32'h0000_0100) return 32'hCAFE_F00D;
        return {addr[15:0], ~addr[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pushExp(input bit isMe, input logic [31:0] data);
        exp_t e;
        e.isMe = isMe;
        e.data = data;
        expQ.push_back(e);
    endtask

    // Wait (bounded) for a Done pulse; optionally check stall each cycle.
    task automatic waitDone(input string name, input bit chkStall, output int cycles);
        bit got;
        got    = 1'b0;
        cycles = 0;
        while (!got && cycles < 40) begin
            @(negedge clock);
            cycles++;
            got = me_Done | if_Done;
            if (chkStall) check({name, " stall"}, {31'd0, stall}, {31'd0, ~got});
        end
        if (!got) begin
            compared++;
            mismatched++;
            $display("FAIL %s: no Done within 40 cycles", name);
        end
    endtask

    // Memory model: ack after ackDelay strobe cycles, for one cycle.
    initial begin
        extBus.ext_Ack    = 1'b0;
        extBus.ext_RdData = 32'd0;
        forever begin
            @(posedge clock);
            #2;
            extBus.ext_Ack = 1'b0;
            if (memOn && (extBus.ext_RdEn || extBus.ext_WrEn)) begin
                if (busyCnt == ackDelay) begin
                    extBus.ext_Ack    = 1'b1;
                    extBus.ext_RdData = memWord(extBus.ext_Addr);
                    busyCnt           = 0;
                end else begin
                    busyCnt++;
                end
            end else begin
                busyCnt = 0;
            end
        end
    end

    // Scoreboard monitor: every Done must match the next expected completion.
    always @(negedge clock) begin
        exp_t e;
        if (me_Done || if_Done) begin
            compared++;
            if (me_Done && if_Done) begin
                mismatched++;
                $display("FAIL done_both: me_Done=1 if_Done=1 required one");
            end else if (expQ.size() == 0) begin
                mismatched++;
                $display("FAIL done_unexpected: me_Done=%0b if_Done=%0b with nothing expected", me_Done, if_Done);
            end else begin
                e = expQ.pop_front();
                if (e.isMe != me_Done) begin
                    mismatched++;
                    $display("FAIL done_owner: got me_Done=%0b required me_Done=%0b", me_Done, e.isMe);
                end else if (me_Done && me_RdData !== e.data) begin
                    mismatched++;
                    $display("FAIL me_RdData: got %h expected %h", me_RdData, e.data);
                end else if (if_Done && if_RdData !== e.data) begin
                    mismatched++;
                    $display("FAIL if_RdData: got %h expected %h", if_RdData, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int strobeCycles;
        reset     = 1'b1;
        if_ReqEn  = 1'b0;
        if_Addr   = 32'd0;
        me_RdEn   = 1'b0;
        me_WrEn   = 1'b0;
        me_Addr   = 32'd0;
        me_WrData = 32'd0;
        repeat (3) @(negedge clock);

        // Reset values.
        check("rst ext_RdEn", {31'd0, extBus.ext_RdEn}, 32'd0);
        check("rst ext_WrEn", {31'd0, extBus.ext_WrEn}, 32'd0);
        check("rst ext_Addr", extBus.ext_Addr, 32'd0);
        check("rst me_Done", {31'd0, me_Done}, 32'd0);
        check("rst if_Done", {31'd0, if_Done}, 32'd0);
        check("rst bus_err", {31'd0, bus_err}, 32'd0);
        check("rst me_RdData", me_RdData, 32'd0);
        check("rst stall", {31'd0, stall}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Single load, ack after 3 strobe cycles.
        ackDelay = 3;
        pushExp(1'b1, 32'hCAFE_F00D);
        me_RdEn = 1'b1;
        me_Addr = 32'h0000_0100;
        #1;
        check("load stall at request", {31'd0, stall}, 32'd1);
        waitDone("load", 1'b1, cyc);
        me_RdEn = 1'b0;
        check("load latency", cyc, 32'd5);

        // Contention: ME store wins, fetch follows.
        ackDelay  = 1;
        pushExp(1'b1, 32'hCAFE_F00D);
        pushExp(1'b0, 32'h0500_FAFF);
        me_WrEn   = 1'b1;
        me_Addr   = 32'h0000_0400;
        me_WrData = 32'h1234_5678;
        if_ReqEn  = 1'b1;
        if_Addr   = 32'h0000_0500;
        @(negedge clock);
        check("cont ext_WrEn", {31'd0, extBus.ext_WrEn}, 32'd1);
        check("cont ext_RdEn", {31'd0, extBus.ext_RdEn}, 32'd0);
        check("cont ext_Addr", extBus.ext_Addr, 32'h0000_0400);
        check("cont ext_WrData", extBus.ext_WrData, 32'h1234_5678);
        me_Addr   = 32'h0000_0FF0;
        me_WrData = 32'h0;
        waitDone("cont store", 1'b0, cyc);
        me_WrEn = 1'b0;
        @(negedge clock);
        check("cont inst ext_RdEn", {31'd0, extBus.ext_RdEn}, 32'd1);
        check("cont inst ext_Addr", extBus.ext_Addr, 32'h0000_0500);
        waitDone("cont fetch", 1'b0, cyc);
        if_ReqEn = 1'b0;

        // Fairness: two back-to-back loads against a held fetch -> ME, IF, ME.
        ackDelay = 0;
        pushExp(1'b1, 32'h0200_FDFF);
        pushExp(1'b0, 32'h0300_FCFF);
        pushExp(1'b1, 32'h0200_FDFF);
        me_RdEn  = 1'b1;
        me_Addr  = 32'h0000_0200;
        if_ReqEn = 1'b1;
        if_Addr  = 32'h0000_0300;
        waitDone("fair load1", 1'b0, cyc);
        check("fair min latency", cyc, 32'd2);
        waitDone("fair fetch", 1'b0, cyc);
        if_ReqEn = 1'b0;
        waitDone("fair load2", 1'b0, cyc);
        me_RdEn = 1'b0;

        // Read+write conflict: one write transaction, read data untouched.
        ackDelay  = 1;
        pushExp(1'b1, 32'h0200_FDFF);
        me_RdEn   = 1'b1;
        me_WrEn   = 1'b1;
        me_Addr   = 32'h0000_0600;
        me_WrData = 32'hDEAD_BEEF;
        @(negedge clock);
        check("rw ext_WrEn", {31'd0, extBus.ext_WrEn}, 32'd1);
        check("rw ext_RdEn", {31'd0, extBus.ext_RdEn}, 32'd0);
        check("rw ext_WrData", extBus.ext_WrData, 32'hDEAD_BEEF);
        waitDone("rw", 1'b0, cyc);
        me_RdEn = 1'b0;
        me_WrEn = 1'b0;
        repeat (3) @(negedge clock);

        // Timeout: no ack, strobe for 4 cycles, Done with zero data.
        memOn = 1'b0;
        pushExp(1'b1, 32'd0);
        me_RdEn = 1'b1;
        me_Addr = 32'h0000_0700;
        strobeCycles = 0;
        cyc = 0;
        @(negedge clock);
        while (extBus.ext_RdEn && cyc < 20) begin
            strobeCycles++;
            cyc++;
            @(negedge clock);
        end
        check("timeout strobe cycles", strobeCycles, 32'd4);
        check("timeout done", {31'd0, me_Done}, 32'd1);
        check("timeout bus_err", {31'd0, bus_err}, 32'd1);
        me_RdEn = 1'b0;
        repeat (3) @(negedge clock);
        check("bus_err sticky", {31'd0, bus_err}, 32'd1);

        // Reset while an ack arrives in the first DATA cycle.
        memOn    = 1'b1;
        ackDelay = 0;
        me_RdEn  = 1'b1;
        me_Addr  = 32'h0000_0800;
        @(negedge clock);
        check("mid ext_RdEn before reset", {31'd0, extBus.ext_RdEn}, 32'd1);
        check("mid ext_Ack present", {31'd0, extBus.ext_Ack}, 32'd1);
        reset   = 1'b1;
        me_RdEn = 1'b0;
        @(negedge clock);
        check("mid ext_RdEn", {31'd0, extBus.ext_RdEn}, 32'd0);
        check("mid me_Done", {31'd0, me_Done}, 32'd0);
        check("mid me_RdData", me_RdData, 32'd0);
        check("mid bus_err", {31'd0, bus_err}, 32'd0);
        check("mid ext_Addr", extBus.ext_Addr, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("mid idle strobe", {31'd0, extBus.ext_RdEn | extBus.ext_WrEn}, 32'd0);
        check("queue drained", expQ.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
